// File: rtl/mmio_pkg.sv
// Shared MMIO map for the UART controller: base nibble, register offsets and STATUS layout.
package mmio_pkg;

   localparam logic [3:0] MMIO_BASE    = 4'h8;
   localparam logic [7:0] OFF_STATUS   = 8'h00;
   localparam logic [7:0] OFF_RX_DATA  = 8'h04;
   localparam logic [7:0] OFF_TX_DATA  = 8'h08;
   localparam logic [7:0] OFF_CTRL     = 8'h0C;
   localparam logic [7:0] OFF_CNT_BASE = 8'h10;

   typedef struct packed {
      logic [7:0] rsvd_hi;
      logic [7:0] tx_count;
      logic [7:0] rx_count;
      logic [4:0] rsvd_lo;
      logic       tx_overflow;
      logic       rx_not_empty;
      logic       tx_not_full;
   } status_t;

   // A 256-deep FIFO holds 256 entries, which does not fit the 8-bit field; report 255.
   function automatic logic [7:0] sat_count8(input logic [8:0] count);
      return (count > 9'd255) ? 8'hFF : count[7:0];
   endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// CPU-side MMIO load/store bus; rdata is returned one cycle after re.
interface mmio_uart_ctrl_if;

   logic [31:0] addr;
   logic        re;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output re, output we, output wdata, input rdata);
   modport slave  (input addr, input re, input we, input wdata, output rdata);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come from the registered count, so they reflect start-of-cycle state.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; pointers and count define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO front end for a UART: RX/TX byte FIFOs, sticky TX overflow and free-running perf counters.
module mmio_uart_ctrl
   import mmio_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned NUM_COUNTERS = 4,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   mmio_uart_ctrl_if.slave         bus,
   input  logic [NUM_COUNTERS-1:0] cnt_inc,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic                 dec_hit;
   logic [7:0]           off;
   logic                 rx_rd, tx_wr, ctrl_wr;
   logic [7:0]           rx_head;
   logic                 rx_full, rx_empty, tx_full, tx_empty;
   logic [CW-1:0]        rx_count, tx_count;
   logic                 ovf_q, ovf_d;
   logic [31:0]          rdata_q, rdata_d, rd_val;
   logic [5:0]           cnt_sel;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_COUNTERS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_COUNTERS];
   status_t              status;
   logic                 unused_bits;

   assign dec_hit = (bus.addr[31:28] == MMIO_BASE);
   assign off     = bus.addr[7:0];
   assign rx_rd   = bus.re && dec_hit && (off == OFF_RX_DATA);
   assign tx_wr   = bus.we && dec_hit && (off == OFF_TX_DATA);
   assign ctrl_wr = bus.we && dec_hit && (off == OFF_CTRL);
   assign cnt_sel = off[7:2] - 6'd4;

   assign rx_ready  = !rx_full;
   assign tx_valid  = !tx_empty;
   assign bus.rdata = rdata_q;

   assign unused_bits = ^{bus.addr[27:8], bus.wdata[31:8], cnt_inc[0]};

   // The FIFOs gate push on !full and pop on !empty, so raw strobes can be passed straight in.
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rx_rd),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_wr),
      .push_data (bus.wdata[7:0]),
      .pop       (tx_ready),
      .pop_data  (tx_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   always_comb begin
      ovf_d = ovf_q;
      if (ctrl_wr)             ovf_d = 1'b0;
      else if (tx_wr && tx_full) ovf_d = 1'b1;
   end

   // Counter 0 counts cycles; the others count their strobe. A clear beats a same-cycle increment.
   always_comb begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (ctrl_wr)                  cnt_d[i] = '0;
         else if (i == 0 || cnt_inc[i]) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      status              = '0;
      status.tx_not_full  = !tx_full;
      status.rx_not_empty = !rx_empty;
      status.tx_overflow  = ovf_q;
      status.rx_count     = sat_count8(9'(rx_count));
      status.tx_count     = sat_count8(9'(tx_count));
   end

   always_comb begin
      rd_val = '0;
      if (dec_hit) begin
         case (off)
            OFF_STATUS:  rd_val = status;
            OFF_RX_DATA: if (!rx_empty) rd_val = {24'b0, rx_head};
            default: begin
               if (off >= OFF_CNT_BASE && off[1:0] == 2'b00) begin
                  for (int i = 0; i < NUM_COUNTERS; i++) begin
                     if (cnt_sel == 6'(i)) rd_val = 32'(cnt_q[i]);
                  end
               end
            end
         endcase
      end
      rdata_d = bus.re ? rd_val : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= '0;
      end else begin
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboard bench for mmio_uart_ctrl: reads and TX bytes queue expectations, monitors compare.
module tb_mmio_uart_ctrl;

   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_RX     = 32'h8000_0004;
   localparam logic [31:0] A_TX     = 32'h8000_0008;
   localparam logic [31:0] A_CTRL   = 32'h8000_000C;
   localparam logic [31:0] A_CNT0   = 32'h8000_0010;
   localparam logic [31:0] A_CNT1   = 32'h8000_0014;
   localparam logic [31:0] A_CNT2   = 32'h8000_0018;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mmio_uart_ctrl_if bus();
   mmio_uart_ctrl_if bus4();

   logic [3:0] cnt_inc, cnt_inc4;
   logic [7:0] rx_data, tx_data, rx_data4, unused_tx_data4;
   logic       rx_valid, rx_ready, tx_valid, tx_ready;
   logic       rx_valid4, rx_ready4, tx_valid4, tx_ready4;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [7:0]  tx_exp[$];
   logic        mon_en  = 1'b0;
   logic        re_seen = 1'b0;

   mmio_uart_ctrl #(.FIFO_DEPTH(8), .NUM_COUNTERS(4), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .cnt_inc(cnt_inc),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   mmio_uart_ctrl #(.FIFO_DEPTH(8), .NUM_COUNTERS(4), .CNT_WIDTH(4)) dut_w4 (
      .clk(clk), .rst(rst), .bus(bus4), .cnt_inc(cnt_inc4),
      .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
      .tx_data(unused_tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic cycle(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      bus.addr = a;
      bus.re   = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(name);
      cycle();
      bus.re = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = 1'b1;
      cycle();
      bus.we = 1'b0;
   endtask

   task automatic rd4(input logic [31:0] a, input logic [31:0] exp, input string name);
      bus4.addr = a;
      bus4.re   = 1'b1;
      cycle();
      check(name, bus4.rdata, exp);
      bus4.re = 1'b0;
   endtask

   always @(posedge clk) re_seen <= bus.re;

   // Read-data and TX-byte monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [31:0] e;
      string       nm;
      logic [7:0]  t;
      if (mon_en) begin
         if (re_seen) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rdata_unexpected: got 0x%08h with no expected entry", bus.rdata);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check(nm, bus.rdata, e);
            end
         end else begin
            check("rdata_idle", bus.rdata, 32'h0);
         end
         if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL tx_unexpected: got 0x%02h with no expected byte", tx_data);
            end else begin
               t = tx_exp.pop_front();
               check("tx_byte", {24'b0, tx_data}, {24'b0, t});
            end
         end
      end
   end

   initial begin
      bus.addr = '0;  bus.re = 1'b0;  bus.we = 1'b0;  bus.wdata = '0;
      bus4.addr = '0; bus4.re = 1'b0; bus4.we = 1'b0; bus4.wdata = '0;
      cnt_inc = '0; cnt_inc4 = '0;
      rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
      rx_data4 = '0; rx_valid4 = 1'b0; tx_ready4 = 1'b1;

      rst = 1'b1;
      cycle(3);
      rst = 1'b0;
      mon_en = 1'b1;
      check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst_w4_rx_ready", {31'b0, rx_ready4}, 32'd1);
      check("rst_w4_tx_valid", {31'b0, tx_valid4}, 32'd0);
      rd(A_STATUS, 32'h0000_0001, "status_reset");

      // RX path: two bytes in, popped in order, then empty read.
      rx_valid = 1'b1;
      rx_data  = 8'h41; cycle();
      rx_data  = 8'h42; cycle();
      rx_valid = 1'b0;
      rd(A_RX, 32'h41, "rx_pop_0");
      rd(A_RX, 32'h42, "rx_pop_1");
      rd(A_RX, 32'h00, "rx_pop_empty");

      // TX overflow: nine stores into an 8-deep FIFO with the transmitter stalled.
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(A_TX, 32'(i));
         if (i < 8) tx_exp.push_back(8'(i));
      end
      rd(A_STATUS, 32'h0008_0004, "status_tx_full_ovf");
      tx_ready = 1'b1;
      cycle(12);
      check("tx_drain", 32'(tx_exp.size()), 32'd0);
      check("tx_valid_drained", {31'b0, tx_valid}, 32'd0);
      rd(A_STATUS, 32'h0000_0005, "status_ovf_sticky");
      wr(A_CTRL, 32'hFFFF_FFFF);
      rd(A_STATUS, 32'h0000_0001, "status_ovf_cleared");

      // RX backpressure: fill, hold the ninth byte, pop one, then drain without loss.
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'h10 + 8'(i);
         cycle();
      end
      rx_data = 8'h18;
      cycle();
      check("rx_full_ready", {31'b0, rx_ready}, 32'd0);
      rd(A_STATUS, 32'h0000_0803, "status_rx_full");
      rd(A_RX, 32'h10, "rx_full_pop");
      check("rx_ready_after_pop", {31'b0, rx_ready}, 32'd1);
      cycle();
      rx_valid = 1'b0;
      for (int i = 0; i < 8; i++) rd(A_RX, 32'h11 + 32'(i), $sformatf("rx_drain_%0d", i));
      rd(A_RX, 32'h00, "rx_drained_empty");

      // Counters: clear after idle, strobes, ignored bit 0, unmapped offsets, clear beats increment.
      cycle(100);
      wr(A_CTRL, 32'h0);
      rd(A_CNT0, 32'd0, "cnt0_after_clear");
      for (int i = 0; i < 5; i++) begin
         cnt_inc = 4'b0010; cycle();
         cnt_inc = 4'b0000; cycle();
      end
      rd(A_CNT1, 32'd5, "cnt1_five");
      cnt_inc = 4'b0001; cycle();
      cnt_inc = 4'b0000;
      rd(A_CNT2, 32'd0, "cnt2_idle");
      rd(32'h8000_0020, 32'd0, "cnt_unmapped");
      rd(32'h8000_0001, 32'd0, "offset_unmapped");
      rd(32'h4000_0010, 32'd0, "addr_undecoded");
      cnt_inc = 4'b0010;
      wr(A_CTRL, 32'h0);
      cnt_inc = 4'b0000;
      rd(A_CNT1, 32'd0, "cnt1_clear_wins");

      // Narrow counters wrap at 2^CNT_WIDTH.
      for (int i = 0; i < 15; i++) begin
         cnt_inc4 = 4'b0010; cycle();
         cnt_inc4 = 4'b0000; cycle();
      end
      rd4(A_CNT1, 32'd15, "w4_cnt1_15");
      cnt_inc4 = 4'b0010; cycle();
      cnt_inc4 = 4'b0000;
      rd4(A_CNT1, 32'd0, "w4_cnt1_wrap");

      // Reset with three bytes in each FIFO; a byte offered during reset is discarded.
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + 32'(i));
      rx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_data = 8'hB0 + 8'(i);
         cycle();
      end
      rx_valid = 1'b0;
      rd(A_STATUS, 32'h0003_0303, "status_pre_rst");
      cycle();
      mon_en   = 1'b0;
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h99;
      cycle(2);
      rst      = 1'b0;
      rx_valid = 1'b0;
      mon_en   = 1'b1;
      check("post_rst_rx_ready", {31'b0, rx_ready}, 32'd1);
      check("post_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      rd(A_STATUS, 32'h0000_0001, "status_post_rst");
      rd(A_RX, 32'h00, "rx_post_rst_empty");
      tx_ready = 1'b1;
      cycle(5);

      check("rd_scoreboard_drain", 32'(exp_q.size()), 32'd0);
      check("tx_scoreboard_drain", 32'(tx_exp.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
